// File: rtl/vga_vram_writer.sv
// vga_vram_writer: buffers CPU stores hitting the video window in a 4-word FIFO and serialises each word into four little-endian byte writes on VRAM port A.
// Ports: clk_50mhz/rst_n (async active-low); Memwrite/Addrin/BUS CPU store side;
// wr_stall/overflow/fifo_count status; vram_we/vram_addr/vram_din registered port-A write.
module vga_vram_writer #(
  parameter logic [31:0] VRAM_BASE  = 32'h0000_C000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk_50mhz,
  input  logic        rst_n,
  input  logic        Memwrite,
  input  logic [31:0] Addrin,
  input  logic [31:0] BUS,
  output logic        wr_stall,
  output logic        overflow,
  output logic [2:0]  fifo_count,
  output logic        vram_we,
  output logic [11:0] vram_addr,
  output logic [7:0]  vram_din
);
  typedef enum logic {IDLE, EMIT} state_t;
  state_t      state, state_d;
  logic [41:0] mem [4];
  logic [41:0] head, hold;
  logic [1:0]  wr_ptr, rd_ptr, idx, idx_d;
  logic        hit, full, push, pop, we_d;
  logic [11:0] addr_d;
  logic [7:0]  din_d;
  logic        unused_ok;
  assign unused_ok = ^{Addrin[1:0], VRAM_BASE[11:0]};
  assign hit      = Memwrite && Addrin[31:12] == VRAM_BASE[31:12];
  assign full     = fifo_count == 3'(FIFO_DEPTH);
  assign push     = hit && !full;
  assign head     = mem[rd_ptr];
  assign wr_stall = full;
  always_ff @(posedge clk_50mhz or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      idx   <= 2'd0;
    end else begin
      state <= state_d;
      idx   <= idx_d;
    end
  // idx is the next byte to emit; byte 0 comes straight from the FIFO head on the
  // pop edge, so every edge while work remains produces one write with no bubble.
  always_comb begin
    state_d = state;
    idx_d   = idx;
    pop     = 1'b0;
    we_d    = 1'b0;
    addr_d  = vram_addr;
    din_d   = vram_din;
    if (state == IDLE) begin
      if (fifo_count != 3'd0) begin
        pop     = 1'b1;
        we_d    = 1'b1;
        addr_d  = {head[41:32], 2'd0};
        din_d   = head[7:0];
        idx_d   = 2'd1;
        state_d = EMIT;
      end
    end else begin
      we_d    = 1'b1;
      addr_d  = {hold[41:32], idx};
      din_d   = hold[{idx, 3'b000} +: 8];
      idx_d   = idx + 2'd1;
      state_d = idx == 2'd3 ? IDLE : EMIT;
    end
  end
  always_ff @(posedge clk_50mhz)
    if (push) mem[wr_ptr] <= {Addrin[11:2], BUS};
  always_ff @(posedge clk_50mhz or negedge rst_n)
    if (!rst_n) begin
      wr_ptr     <= 2'd0;
      rd_ptr     <= 2'd0;
      fifo_count <= 3'd0;
      hold       <= '0;
      overflow   <= 1'b0;
      vram_we    <= 1'b0;
      vram_addr  <= 12'd0;
      vram_din   <= 8'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop) begin
        rd_ptr <= rd_ptr + 2'd1;
        hold   <= head;
      end
      fifo_count <= fifo_count + 3'(push) - 3'(pop);
      if (hit && full) overflow <= 1'b1;
      vram_we   <= we_d;
      vram_addr <= addr_d;
      vram_din  <= din_d;
    end
endmodule

// File: doc/vga_vram_writer.md
# vga_vram_writer

Upstream feeder for the VGA display controller: decodes CPU store cycles (`Memwrite`, `Addrin`, `BUS`) that fall inside the video-RAM address window. Accepted 32-bit words are buffered in a 4-entry FIFO. Each word is serialised into four 8-bit byte writes on the write port (port A) of the VGA character/pixel RAM, whose read port (`doutb`) the VGA scan logic consumes. The block decouples single-cycle CPU stores from the byte-wide video memory and reports stall and overflow status back to the CPU side.

## Interface

Parameters
- `VRAM_BASE`, 32'h0000_C000, base of the 4 KB video window; bits [11:0] must be zero.
- `FIFO_DEPTH`, 4, word FIFO depth; fixed at 4 in this revision.

Ports
- `clk_50mhz`  in  1  system clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `Memwrite`  in  1  CPU store strobe, one cycle per store.
- `Addrin`  in  32  CPU byte address of the store.
- `BUS`  in  32  CPU store data; byte 0 = `BUS[7:0]`.
- `wr_stall`  out  1  high while the FIFO holds 4 entries; CPU must not issue video stores.
- `overflow`  out  1  sticky; set when a hit store is dropped; cleared only by reset.
- `fifo_count`  out  3  current FIFO occupancy, 0..4.
- `vram_we`  out  1  port-A write enable, registered.
- `vram_addr`  out  12  port-A byte address, registered.
- `vram_din`  out  8  port-A write data, registered.

## Operation

- Hit = `Memwrite` && `Addrin[31:12]` == `VRAM_BASE[31:12]`. `Addrin[1:0]` is ignored, giving word-aligned stores. Non-hit strobes have no effect.
- Push: on a hit with `fifo_count` < 4, the pair {`Addrin[11:2]`, `BUS`} is written to the FIFO tail.
- Drop: a hit with `fifo_count` == 4 is discarded and sets `overflow`. Fullness is evaluated on the registered count before any same-edge pop. A pop in the same cycle does not make room for the store.
- Drain FSM, states IDLE and EMIT, with 2-bit byte index `idx`:
  - IDLE: if `fifo_count` != 0, pop the head into the hold register, set `idx`=0, go to EMIT. Otherwise stay, with `vram_we`=0.
  - EMIT: drive `vram_we`=1, `vram_addr`={offset, `idx`}, `vram_din`=word byte `idx`, then `idx`++.
  - After `idx`==3: if `fifo_count` != 0, pop the next entry at the same edge and continue EMIT at `idx`=0 with no bubble. Otherwise return to IDLE.
- Byte order is little-endian: byte 0 goes to the lowest address.
- Simultaneous push and pop on the same edge: `fifo_count` is unchanged and the entry order is preserved.
- `wr_stall` = (`fifo_count` == 4), derived from the registered count.

## Timing

- Reset (asserted asynchronously) forces immediately:
  - `vram_we`=0, `vram_addr`=0, `vram_din`=0
  - `fifo_count`=0, `wr_stall`=0, `overflow`=0
  - FSM in IDLE
- Reset mid-drain: remaining bytes and FIFO contents are discarded. No write occurs after `rst_n` falls.
- Latency: a store sampled at edge N appears in the FIFO after edge N. The first byte write (`vram_we`=1) is visible after edge N+1. Bytes 1–3 follow after edges N+2, N+3 and N+4.
- Throughput: 1 word per 4 cycles sustained, with 4 byte writes per word.
- `vram_*` outputs change only at clock edges. Each write is valid for exactly one cycle.

## Test plan

- Single store: `Addrin`=32'h0000_C010, `BUS`=32'h4433_2211, 1-cycle strobe. Required response: four consecutive `vram_we` cycles writing addresses 0x010/0x011/0x012/0x013 with data 11/22/33/44. First write visible 2 edges after the strobe; `fifo_count` returns to 0.
- Out-of-window store: `Addrin`=32'h0000_D000. Required response: no `vram_we`, `fifo_count` stays 0, `overflow` stays 0.
- Burst of 6 back-to-back hit strobes from an empty FIFO. Required response:
  - stores 1–5 accepted, store 6 dropped;
  - `overflow`=1, `wr_stall` high from the 5th store's edge until the next pop;
  - exactly 20 contiguous byte writes, in store order.
- Unaligned address: `Addrin`=32'h0000_C007. Required response: writes to 0x004..0x007.
- Reset mid-drain: assert `rst_n`=0 after the 2nd byte of a word with 2 words queued. Required response: `vram_we` drops immediately, `fifo_count`=0, `overflow`=0, and no writes occur after release until a new store.
- Window end: `Addrin`=32'h0000_CFFC, `BUS`=32'hDDCC_BBAA. Required response: writes to 0xFFC..0xFFF with data AA, BB, CC, DD, and no address wrap.
